// File: rtl/scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scan_decoder                                               |
// | Description : Active-low one-hot select decoder. In direct mode the      |
// |               index is loaded from a; in scan mode a prescaler advances  |
// |               the index every DIV cycles, wrapping at N_OUT-1.           |
// |               Optional macro SCAN_DECODER_BLANK_EN adds one blanking     |
// |               cycle (b all ones) on every scan advance.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module scan_decoder #(
    parameter int SEL_W = 3,
    parameter int N_OUT = 8,
    parameter int DIV   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] a,
    output logic [N_OUT-1:0] b,
    output logic [SEL_W-1:0] idx,
    output logic             step
);

    // A single-bit prescaler is kept even for DIV=1; it then sits at 0.
    localparam int               c_PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(DIV - 1);
    localparam logic [SEL_W-1:0]   c_IDX_MAX = SEL_W'(N_OUT - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [SEL_W-1:0]   r_idx;
    logic [N_OUT-1:0]   r_b;
    logic               r_step;

    logic [c_PRE_W-1:0] w_pre_nxt;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [N_OUT-1:0]   w_b_nxt;
    logic               w_step_nxt;
    logic               w_b_off;

    // Next index/prescaler/step and the decoded select pattern for next cycle.
    always_comb begin
        w_pre_nxt  = r_pre;
        w_idx_nxt  = r_idx;
        w_step_nxt = 1'b0;
        w_b_off    = 1'b1;
        w_b_nxt    = '1;
        if (en) begin
            if (!mode) begin
                // Direct mode: prescaler parked at 0 so a later scan starts fresh.
                w_pre_nxt = '0;
                if (int'(a) < N_OUT) begin
                    w_idx_nxt = a;
                    w_b_off   = 1'b0;
                end
            end else begin
                w_b_off = 1'b0;
                if (r_pre == c_PRE_MAX) begin
                    w_pre_nxt  = '0;
                    w_idx_nxt  = (r_idx >= c_IDX_MAX) ? '0 : r_idx + SEL_W'(1);
                    w_step_nxt = 1'b1;
`ifdef SCAN_DECODER_BLANK_EN
                    // Dead time: outputs released for the cycle the new index appears.
                    w_b_off = 1'b1;
`endif
                end else begin
                    w_pre_nxt = r_pre + c_PRE_W'(1);
                end
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            w_b_nxt[i] = w_b_off | (w_idx_nxt != SEL_W'(i));
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= '0;
            r_idx  <= '0;
            r_b    <= '1;
            r_step <= 1'b0;
        end else begin
            r_pre  <= w_pre_nxt;
            r_idx  <= w_idx_nxt;
            r_b    <= w_b_nxt;
            r_step <= w_step_nxt;
        end
    end

    assign b    = r_b;
    assign idx  = r_idx;
    assign step = r_step;

endmodule
`default_nettype wire

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3, index width in bits.
REQ-002 SHALL have parameter N_OUT, default 8, number of select outputs; legal range 2 <= N_OUT <= 2**SEL_W.
REQ-003 SHALL have parameter DIV, default 50000, clock cycles per scan step; legal range DIV >= 1, DIV >= 2 when SCAN_DECODER_BLANK_EN is defined.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, block enable.
REQ-007 SHALL have port mode, input, 1: 0 = direct (index from a), 1 = scan (index self-advancing).
REQ-008 SHALL have port a, input, SEL_W, direct-mode index.
REQ-009 SHALL have port b, output, N_OUT, registered active-low one-hot select.
REQ-010 SHALL have port idx, output, SEL_W, registered current index.
REQ-011 SHALL have port step, output, 1, registered one-cycle pulse when idx advances in scan mode.

Function
REQ-012 Output b SHALL have bit idx low and all other bits high whenever the block is active and not blanked.
REQ-013 Inactive case: en=0 SHALL force b to all ones, hold idx and the prescaler, and hold step at 0.
REQ-014 Direct-mode load: with en=1, mode=0 and a < N_OUT, idx and b SHALL take the value for a one cycle after a is sampled (latency 1).
REQ-015 Direct-mode out-of-range: with en=1, mode=0 and a >= N_OUT, b SHALL be all ones one cycle later and idx SHALL hold.
REQ-016 Direct-mode prescaler: while in direct mode, the prescaler SHALL be held at 0 and step SHALL be 0.
REQ-017 Scan-mode prescaler count: with en=1 and mode=1, the prescaler SHALL count 0..DIV-1 and wrap to 0.
REQ-018 Scan-mode advance: on the cycle the prescaler is at DIV-1, the next edge SHALL advance idx by 1 and assert step for exactly one cycle.
REQ-019 Scan-mode wrap: idx = N_OUT-1 SHALL advance to 0; indices >= N_OUT never occur in scan mode.
REQ-020 With DIV=1, idx SHALL advance on every enabled scan cycle and step SHALL stay high.
REQ-021 Mode switch 0->1 SHALL start scanning from the current idx with the prescaler at 0; the first advance occurs DIV cycles later.
REQ-022 Mode switch 1->0 SHALL take effect on the next edge per REQ-014/015.
REQ-023 Enable deassertion mid-step SHALL freeze the prescaler count; reassertion resumes from the frozen count without restarting.
REQ-024 b SHALL never have more than one bit low in any cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL set idx=0, prescaler=0, step=0, b=all ones, overriding en, mode and a.
REQ-026 Reset asserted mid-step SHALL discard the partial prescaler count; after release with en=1, mode=1, the first advance occurs DIV cycles later.

Configuration
REQ-027 Macro SCAN_DECODER_BLANK_EN SHALL control dead-time blanking.
REQ-028 With SCAN_DECODER_BLANK_EN defined, in scan mode b SHALL be forced all ones for the single cycle in which the prescaler equals 0 after each advance, i.e. the cycle step is high, while idx already shows the new value.
REQ-029 Without SCAN_DECODER_BLANK_EN, no blanking cycle SHALL exist; b follows idx with no gap.
REQ-030 Blanking SHALL never apply in direct mode under either build.

Verification (SEL_W=3, N_OUT=6, DIV=4 unless stated)
REQ-031 Direct sweep: rst 1 cycle, en=1, mode=0, a=0..5 one per cycle -> b = 111110, 111101, 111011, 110111, 101111, 011111, each one cycle after a; a=6 and a=7 -> b=111111 and idx holds 5.
REQ-032 Scan wrap: en=1, mode=1 for 30 cycles -> idx sequence 0,1,2,3,4,5,0,1 with each value held 4 cycles, one step pulse per change, no index >= 6; with SCAN_DECODER_BLANK_EN, b=111111 exactly on step cycles.
REQ-033 Enable freeze: scan, drop en after 2 prescaler cycles for 5 cycles -> b=111111 and idx constant during freeze; next advance 2 cycles after en returns.
REQ-034 Reset mid-step: scan to idx=3, assert rst at prescaler=2 -> next cycle idx=0, b=111111, step=0; after release the first advance occurs 4 cycles later.
REQ-035 Mode switch: direct a=4, then mode=1 -> idx=4 for 4 cycles, then 5, then 0; with DIV=1 step stays high and idx changes every cycle.
